// File: rtl/weight_fetch_ctrl.sv
// Weight fetch sequencer: reads the five column words of one kernel from BRAM,
// drives the preload shift-enable aligned with read data, then commits with a swap pulse.
module weight_fetch_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int BRAM_LAT  = 1,
  parameter int IDX_W     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  kernel_idx,
  input  logic              abort,
  input  logic              compute_idle,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              load_weight_preload,
  output logic              weight_swap,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    DRAIN     = 2'd2,
    WAIT_SWAP = 2'd3
  } state_t;

  localparam int SUM_W = ADDR_W + IDX_W + 3;
  localparam logic [2:0] NUM_COLS = 3'd5;
  localparam logic [1:0] DRAIN_LAST = 2'(BRAM_LAT - 1);

  state_t              state_reg, state_next;
  logic [2:0]          col_reg, col_next;
  logic [1:0]          drain_reg, drain_next;
  logic [ADDR_W-1:0]   kbase_reg, kbase_next;
  logic [SUM_W-1:0]    kbase_sum;
  logic [BRAM_LAT-1:0] load_pipe_reg;

  logic                bram_en_next;
  logic [ADDR_W-1:0]   bram_addr_next;
  logic                busy_next;
  logic                done_next;
  logic                swap_next;

  // Kernel base address, wide enough that only the final truncation wraps.
  assign kbase_sum = SUM_W'(BASE_ADDR) + SUM_W'(kernel_idx) * SUM_W'(5);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      col_reg   <= '0;
      drain_reg <= '0;
      kbase_reg <= '0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      drain_reg <= drain_next;
      kbase_reg <= kbase_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    drain_next = drain_reg;
    kbase_next = kbase_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            state_next = FETCH;
            kbase_next = kbase_sum[ADDR_W-1:0];
            col_next   = 3'd1;
          end
        end
        FETCH: begin
          if (col_reg == NUM_COLS) begin
            state_next = DRAIN;
            drain_next = '0;
          end else begin
            col_next = col_reg + 3'd1;
          end
        end
        DRAIN: begin
          if (drain_reg == DRAIN_LAST) begin
            state_next = WAIT_SWAP;
          end else begin
            drain_next = drain_reg + 2'd1;
          end
        end
        WAIT_SWAP: begin
          if (compute_idle) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output values for the next cycle; registered below so no input reaches an output combinationally.
  always_comb begin
    bram_en_next   = 1'b0;
    bram_addr_next = bram_addr;
    busy_next      = (state_next != IDLE);
    done_next      = 1'b0;
    swap_next      = 1'b0;
    if (!abort) begin
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            bram_en_next   = 1'b1;
            bram_addr_next = kbase_sum[ADDR_W-1:0];
          end
        end
        FETCH: begin
          if (col_reg != NUM_COLS) begin
            bram_en_next   = 1'b1;
            bram_addr_next = kbase_reg + ADDR_W'(col_reg);
          end
        end
        WAIT_SWAP: begin
          if (compute_idle) begin
            done_next = 1'b1;
            swap_next = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_en     <= 1'b0;
      bram_addr   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      weight_swap <= 1'b0;
    end else begin
      bram_en     <= bram_en_next;
      bram_addr   <= bram_addr_next;
      busy        <= busy_next;
      done        <= done_next;
      weight_swap <= swap_next;
    end
  end

  // Shift-enable tracks bram_en through the BRAM latency; abort flushes in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_pipe_reg <= '0;
    end else if (abort) begin
      load_pipe_reg <= '0;
    end else begin
      load_pipe_reg <= BRAM_LAT'({load_pipe_reg, bram_en});
    end
  end

  assign load_weight_preload = load_pipe_reg[BRAM_LAT-1];

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: three instances (latency 1/3/2, one with wrapping base)
// share stimulus; each is checked against a transaction-timeline model plus a BRAM/preload emulation.
module tb_weight_fetch_ctrl;

  localparam int ND = 3;
  localparam int LATS  [ND] = '{1, 3, 2};
  localparam int BASES [ND] = '{0, 0, 250};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       compute_idle = 1'b0;
  logic [4:0] kernel_idx = '0;

  logic [ND-1:0]      en_o, ld_o, swap_o, busy_o, done_o;
  logic [ND-1:0][7:0] addr_o;

  always #5 clk = ~clk;

  weight_fetch_ctrl #(.ADDR_W(8), .BASE_ADDR(0), .BRAM_LAT(1), .IDX_W(5)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .kernel_idx(kernel_idx), .abort(abort),
    .compute_idle(compute_idle), .bram_en(en_o[0]), .bram_addr(addr_o[0]),
    .load_weight_preload(ld_o[0]), .weight_swap(swap_o[0]), .busy(busy_o[0]), .done(done_o[0]));

  weight_fetch_ctrl #(.ADDR_W(8), .BASE_ADDR(0), .BRAM_LAT(3), .IDX_W(5)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .kernel_idx(kernel_idx), .abort(abort),
    .compute_idle(compute_idle), .bram_en(en_o[1]), .bram_addr(addr_o[1]),
    .load_weight_preload(ld_o[1]), .weight_swap(swap_o[1]), .busy(busy_o[1]), .done(done_o[1]));

  weight_fetch_ctrl #(.ADDR_W(8), .BASE_ADDR(250), .BRAM_LAT(2), .IDX_W(5)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .kernel_idx(kernel_idx), .abort(abort),
    .compute_idle(compute_idle), .bram_en(en_o[2]), .bram_addr(addr_o[2]),
    .load_weight_preload(ld_o[2]), .weight_swap(swap_o[2]), .busy(busy_o[2]), .done(done_o[2]));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: an accepted transaction is described only by its start cycle, kernel and swap cycle.
  int m_active [ND];
  int m_t0     [ND];
  int m_idx    [ND];
  int m_swap   [ND];

  logic [4:0]  mem [256];
  int          hist [ND][4];
  logic [24:0] pre [ND];

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d cycle %0d: got %0h expected %0h", tag, d, cyc, obs, exp);
    end
  endtask

  function automatic logic [24:0] kernel_of(input int d, input int idx);
    logic [24:0] k;
    k = '0;
    for (int col = 0; col < 5; col++) begin
      k[col*5 +: 5] = mem[8'((BASES[d] + 5 * idx + col) % 256)];
    end
    return k;
  endfunction

  task automatic check_all();
    for (int d = 0; d < ND; d++) begin
      int  lat;
      int  t0;
      bit  act, e_en, e_ld, e_sw;
      lat  = LATS[d];
      t0   = m_t0[d];
      act  = (m_active[d] != 0);
      e_en = act && (cyc <= t0 + 5);
      e_ld = act && (cyc >= t0 + 1 + lat) && (cyc <= t0 + 5 + lat);
      e_sw = (cyc == m_swap[d]);
      chk("bram_en", d, 32'(en_o[d]), 32'(e_en));
      chk("load", d, 32'(ld_o[d]), 32'(e_ld));
      chk("busy", d, 32'(busy_o[d]), 32'(act));
      chk("weight_swap", d, 32'(swap_o[d]), 32'(e_sw));
      chk("done", d, 32'(done_o[d]), 32'(e_sw));
      if (e_en) begin
        chk("bram_addr", d, 32'(addr_o[d]), 32'((BASES[d] + 5 * m_idx[d] + cyc - t0 - 1) % 256));
      end
      // BRAM returns the word addressed lat cycles ago; preload shifts it in from the top.
      for (int i = 3; i > 0; i--) hist[d][i] = hist[d][i-1];
      hist[d][0] = int'(addr_o[d]);
      if (ld_o[d] === 1'b1) begin
        pre[d] = {mem[8'(hist[d][lat])], pre[d][24:5]};
      end
      if (e_sw) begin
        chk("preload", d, 32'(pre[d]), 32'(kernel_of(d, m_idx[d])));
      end
    end
  endtask

  task automatic update(input logic s, input logic [4:0] k, input logic a, input logic ci);
    for (int d = 0; d < ND; d++) begin
      if (m_active[d] != 0) begin
        if (a) begin
          m_active[d] = 0;
        end else if (cyc >= m_t0[d] + 6 + LATS[d] && ci) begin
          m_active[d] = 0;
          m_swap[d]   = cyc + 1;
        end
      end else if (s && !a) begin
        m_active[d] = 1;
        m_t0[d]     = cyc;
        m_idx[d]    = int'(k);
      end
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic s, input logic [4:0] k, input logic a, input logic ci);
    start = s;
    kernel_idx = k;
    abort = a;
    compute_idle = ci;
    @(negedge clk);
    check_all();
    $display("cycle %0d start=%0b idx=%0d abort=%0b idle=%0b | en=%b addr0=%0d ld=%b busy=%b swap=%b",
             cyc, s, k, a, ci, en_o, addr_o[0], ld_o, busy_o, swap_o);
    update(s, k, a, ci);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_zero(input string tag);
    for (int d = 0; d < ND; d++) begin
      chk({tag, "_en"}, d, 32'(en_o[d]), 32'd0);
      chk({tag, "_addr"}, d, 32'(addr_o[d]), 32'd0);
      chk({tag, "_load"}, d, 32'(ld_o[d]), 32'd0);
      chk({tag, "_busy"}, d, 32'(busy_o[d]), 32'd0);
      chk({tag, "_swap"}, d, 32'(swap_o[d]), 32'd0);
      chk({tag, "_done"}, d, 32'(done_o[d]), 32'd0);
    end
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear without waiting for an edge.
  task automatic reset_mid();
    start = 1'b0;
    abort = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    $display("cycle %0d async reset asserted", cyc);
    for (int d = 0; d < ND; d++) begin
      m_active[d] = 0;
      m_swap[d]   = -1;
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int c0;
    for (int i = 0; i < 256; i++) mem[i] = 5'($urandom_range(0, 31));
    mem[15] = 5'h01; mem[16] = 5'h02; mem[17] = 5'h04; mem[18] = 5'h08; mem[19] = 5'h10;
    for (int d = 0; d < ND; d++) begin
      m_active[d] = 0;
      m_t0[d]     = 0;
      m_idx[d]    = 0;
      m_swap[d]   = -1;
      pre[d]      = '0;
      for (int i = 0; i < 4; i++) hist[d][i] = 0;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;

    // Kernel 3 with compute idle; a second start in cycle 3 must be ignored.
    step(1, 5'd3, 0, 1);
    step(0, 5'd0, 0, 1);
    step(0, 5'd0, 0, 1);
    step(1, 5'd7, 0, 1);
    repeat (4) step(0, 5'd0, 0, 1);
    // Words 01,02,04,08,10 stack column 0 into bits [4:0].
    chk("kernel_literal", 0, 32'(pre[0]), 32'h0104_1041);
    // Start in the done cycle of the latency-1 instance is accepted there.
    step(1, 5'd4, 0, 1);
    repeat (12) step(0, 5'd0, 0, 1);

    // Compute array busy for 20 cycles: swap must wait for compute_idle.
    step(1, 5'd2, 0, 0);
    repeat (19) step(0, 5'd0, 0, 0);
    step(0, 5'd0, 0, 1);
    repeat (5) step(0, 5'd0, 0, 1);

    // Abort in cycle 3 of a fetch, then abort together with start while idle.
    step(1, 5'd9, 0, 1);
    step(0, 5'd0, 0, 1);
    step(0, 5'd0, 0, 1);
    step(1, 5'd6, 1, 1);
    repeat (8) step(0, 5'd0, 0, 1);
    step(1, 5'd5, 1, 1);
    repeat (3) step(0, 5'd0, 0, 1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom % 4 == 0), 5'($urandom), 1'($urandom % 24 == 0), 1'($urandom % 3 != 0));
    end
    repeat (15) step(0, 5'd0, 0, 1);

    // Kernel 1 on the wrapping instance, reset asserted in cycle 4.
    c0 = cyc;
    step(1, 5'd1, 0, 1);
    repeat (3) step(0, 5'd0, 0, 1);
    reset_mid();
    repeat (6) step(0, 5'd0, 0, 1);
    $display("reset test began at cycle %0d", c0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_fetch_ctrl.md
Name: weight_fetch_ctrl

Overview:
- Sequencer directly upstream of the 5x5 binary-weight preload shift register.
- On a start request it fetches the five 5-bit column words of one kernel from weight BRAM. It drives the preload shift-enable aligned with BRAM read data.
- It then waits for the compute array to go idle and issues a one-cycle swap pulse, committing the preloaded 25-bit kernel to the active weights.
- It reports busy/done to the layer controller.

Parameters:
ADDR_W, 8, BRAM address width
BASE_ADDR, 0, BRAM word address of kernel 0 column 0
BRAM_LAT, 1, BRAM read latency in cycles (legal 1..3)
IDX_W, 5, width of kernel index

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request fetch of kernel kernel_idx; sampled only in IDLE
kernel_idx  input  IDX_W  kernel number; latched when start is accepted
abort  input  1  synchronous cancel of any operation in progress
compute_idle  input  1  compute array not using active weights
bram_en  output  1  BRAM read enable
bram_addr  output  ADDR_W  BRAM read address
load_weight_preload  output  1  shift-enable to preload register, aligned with BRAM data
weight_swap  output  1  one-cycle pulse: copy preload into active weights
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: clk; reset rst_n, asynchronous, active-low.
- Reset values: all outputs 0, bram_addr 0, state IDLE, latency pipe cleared.
- All outputs are registered. There are no combinational paths from inputs to outputs.

States: IDLE, FETCH, DRAIN, WAIT_SWAP.
- IDLE:
  - start=1 (and abort=0) at a clock edge latches kernel_idx and enters FETCH.
  - busy goes high next cycle.
- FETCH:
  - Exactly 5 consecutive cycles with bram_en=1.
  - bram_addr = BASE_ADDR + 5*kernel_idx + col, for col = 0,1,2,3,4 in that order.
  - Sum is computed at ADDR_W+IDX_W+3 bits, truncated modulo 2^ADDR_W (address wrap is legal, not flagged).
  - Column 0 is read first so it ends in preload bits [4:0] after 5 shifts.
- load_weight_preload: equals bram_en delayed by exactly BRAM_LAT cycles through a shift pipe, giving exactly 5 contiguous high cycles per fetch.
- DRAIN: lasts BRAM_LAT cycles after FETCH, with bram_en=0; the pipe empties.
- WAIT_SWAP:
  - Entered the cycle after the last load_weight_preload pulse.
  - Remains until compute_idle=1 is sampled.
  - Next cycle: weight_swap=1, done=1 and busy=0 for exactly one cycle, then state IDLE.
- Latency with compute_idle held high: start sampled at edge of cycle 0 gives bram_en in cycles 1-5, load in cycles 1+BRAM_LAT to 5+BRAM_LAT, and weight_swap/done in cycle 7+BRAM_LAT.
- start while busy: ignored and not queued.
- start in the cycle done is high: accepted, since the state is already IDLE.
- abort (any non-IDLE state, highest priority):
  - Next cycle: state IDLE, bram_en=0, latency pipe cleared so no further load pulses, busy=0.
  - No done or weight_swap is issued.
  - The preload register may hold a partial kernel; the active weights are untouched.
- abort and start in the same IDLE cycle: abort wins and start is dropped.
- compute_idle toggling during FETCH/DRAIN has no effect; it is only sampled in WAIT_SWAP.
- Async reset mid-operation: immediate return to reset values; no pulses after release until a new start.

Test Plan:
- BRAM_LAT=1, BASE_ADDR=0, kernel_idx=3, compute_idle=1 -> bram_addr 15,16,17,18,19 in cycles 1-5; load high cycles 2-6; BRAM model words 0x01,0x02,0x04,0x08,0x10 give preload output 0x1041041 (25'b1_0000_0100_0001_0000_0100_0001); swap/done in cycle 8.
- BRAM_LAT=3, same stimulus -> load high cycles 4-8; swap/done in cycle 10; exactly 5 load pulses.
- compute_idle=0 until cycle 20 -> busy held high and no swap before cycle 21; swap and done both in cycle 21 for one cycle.
- start pulsed again in cycle 3 -> ignored, bram_addr sequence unchanged. start raised in the done cycle -> second fetch begins next cycle, bram_en back-to-back after one gap.
- abort in cycle 3 -> bram_en low from cycle 4, no load pulses after cycle 3+BRAM_LAT, busy low, done/swap never assert.
- BASE_ADDR=250, ADDR_W=8, kernel_idx=1 -> addresses 255,0,1,2,3 (wrap); rst_n low in cycle 4 -> all outputs 0 immediately and stay 0 after release without start.
